// File: rtl/framing_pkg.sv
// Shared definitions for the packet framing controller.
//   - Ten 4-bit select encodings for the symbol multiplexer.
//   - The framing state enum.
//   - The SKP ordered-set length and the interval counter width.
//   - A helper mapping a framing state to its default multiplexer select.
package framing_pkg;

  localparam logic [3:0] MUX_TLP = 4'd0;
  localparam logic [3:0] MUX_COM = 4'd1;
  localparam logic [3:0] MUX_PAD = 4'd2;
  localparam logic [3:0] MUX_SKP = 4'd3;
  localparam logic [3:0] MUX_STP = 4'd4;
  localparam logic [3:0] MUX_SDP = 4'd5;
  localparam logic [3:0] MUX_END = 4'd6;
  localparam logic [3:0] MUX_EDB = 4'd7;
  localparam logic [3:0] MUX_FTS = 4'd8;
  localparam logic [3:0] MUX_IDL = 4'd9;

  // Number of SKP symbols that follow COM in one ordered set.
  localparam logic [1:0] SKP_SET_LEN = 2'd3;

  // Wide enough for the largest legal interval (4095).
  localparam int SKP_CNT_W = 12;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    END     = 3'd3,
    SKP_COM = 3'd4,
    SKP_SET = 3'd5
  } frame_state_e;

  // Default multiplexer select shown while in a given state.
  function automatic logic [3:0] state_ctrl(input frame_state_e st);
    logic [3:0] sel;
    case (st)
      IDLE:    sel = MUX_IDL;
      START:   sel = MUX_STP;
      DATA:    sel = MUX_TLP;
      END:     sel = MUX_END;
      SKP_COM: sel = MUX_COM;
      SKP_SET: sel = MUX_SKP;
      default: sel = MUX_IDL;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/framing_controller_if.sv
// Bundle between the transaction-layer byte source, the framing controller
// and the symbol multiplexer.
//   tlpREQ/tlpLEN/tlpABORT : byte source -> controller
//   tlpACK/tlpRD           : controller -> byte source
//   muxCTRL/muxENB         : controller -> multiplexer
//   skpPEND                : controller status
// master = controller side, slave = source/multiplexer side.
interface framing_controller_if;

  logic       tlpREQ;
  logic [7:0] tlpLEN;
  logic       tlpABORT;
  logic       tlpACK;
  logic       tlpRD;
  logic [3:0] muxCTRL;
  logic       muxENB;
  logic       skpPEND;

  modport master (
    input  tlpREQ, tlpLEN, tlpABORT,
    output tlpACK, tlpRD, muxCTRL, muxENB, skpPEND
  );

  modport slave (
    output tlpREQ, tlpLEN, tlpABORT,
    input  tlpACK, tlpRD, muxCTRL, muxENB, skpPEND
  );

endinterface

// File: rtl/skp_scheduler.sv
// SKP ordered-set request scheduler.
// A free-running counter wraps every SKP_INTERVAL cycles; each wrap raises
// a single outstanding request that is cleared when the framer enters
// SKP_COM. A wrap coinciding with the clear keeps the request set.
// Ports:
//   ctrlCLK       clock
//   ctrlRST       synchronous active-high reset
//   skp_clr_s     framer is entering SKP_COM this cycle
//   skp_pend_r    request outstanding (registered)
module skp_scheduler
  import framing_pkg::*;
#(
  parameter int unsigned SKP_INTERVAL = 1180
) (
  input  logic ctrlCLK,
  input  logic ctrlRST,
  input  logic skp_clr_s,
  output logic skp_pend_r
);

  localparam logic [SKP_CNT_W-1:0] CNT_LAST = SKP_CNT_W'(SKP_INTERVAL - 32'd1);

  logic [SKP_CNT_W-1:0] cnt_r;
  logic                 wrap_s;

  // Wrap detection on the last count of the interval.
  always_comb begin
    wrap_s = (cnt_r == CNT_LAST);
  end

  // Interval counter and request flag; set has priority over clear.
  always_ff @(posedge ctrlCLK) begin
    if (ctrlRST) begin
      cnt_r      <= {SKP_CNT_W{1'b0}};
      skp_pend_r <= 1'b0;
    end else begin
      if (wrap_s) begin
        cnt_r <= {SKP_CNT_W{1'b0}};
      end else begin
        cnt_r <= cnt_r + 12'd1;
      end
      if (wrap_s) begin
        skp_pend_r <= 1'b1;
      end else if (skp_clr_s) begin
        skp_pend_r <= 1'b0;
      end else begin
        skp_pend_r <= skp_pend_r;
      end
    end
  end

endmodule

// File: rtl/framing_controller.sv
// Packet framing sequencer for the symbol multiplexer.
// Emits STP, N TLP bytes and END per packet, inserts SKP ordered sets
// (COM + 3 x SKP) at packet boundaries and IDL when nothing is pending.
// All outputs are registered and decoded from the next state, so the
// select appears in the same cycle the state is entered.
// Ports:
//   ctrlCLK  clock (same as the multiplexer clock muxCLK)
//   ctrlRST  synchronous active-high reset
//   bus      framing_controller_if.master (tlpREQ/LEN/ABORT in,
//            tlpACK/tlpRD/muxCTRL/muxENB/skpPEND out)
// Build option: FRAMING_ABORT_EN enables tlpABORT in DATA, which replaces
// the rest of the packet with EDB.
module framing_controller
  import framing_pkg::*;
#(
  parameter int unsigned SKP_INTERVAL = 1180
) (
  input logic                  ctrlCLK,
  input logic                  ctrlRST,
  framing_controller_if.master bus
);

  frame_state_e state_r;
  frame_state_e state_s;
  logic [7:0]   remain_r;
  logic [7:0]   remain_s;
  logic [1:0]   set_cnt_r;
  logic [1:0]   set_cnt_s;
  logic [3:0]   ctrl_s;
  logic         edb_s;
  logic         abort_s;
  logic         skp_pend_s;
  logic         skp_clr_s;
  logic [3:0]   ctrl_r;
  logic         ack_r;
  logic         rd_r;
  logic         enb_r;

`ifdef FRAMING_ABORT_EN
  assign abort_s = bus.tlpABORT;
`else
  logic unused_abort_s;
  assign unused_abort_s = bus.tlpABORT;
  assign abort_s        = 1'b0;
`endif

  skp_scheduler #(
    .SKP_INTERVAL (SKP_INTERVAL)
  ) u_skp_scheduler (
    .ctrlCLK    (ctrlCLK),
    .ctrlRST    (ctrlRST),
    .skp_clr_s  (skp_clr_s),
    .skp_pend_r (skp_pend_s)
  );

  // Next-state, byte counter and next-select decode.
  always_comb begin
    state_s   = state_r;
    remain_s  = remain_r;
    set_cnt_s = set_cnt_r;
    edb_s     = 1'b0;
    case (state_r)
      // Packet boundary: SKP request beats a waiting packet.
      IDLE, END: begin
        if (skp_pend_s) begin
          state_s = SKP_COM;
        end else if (bus.tlpREQ) begin
          state_s  = START;
          remain_s = bus.tlpLEN;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (remain_r != 8'd0) begin
          state_s = DATA;
        end else begin
          state_s = END;
        end
      end
      // remain_r holds the bytes left including the current one.
      DATA: begin
        if (abort_s) begin
          state_s = END;
          edb_s   = 1'b1;
        end else if (remain_r == 8'd1) begin
          state_s = END;
        end else begin
          state_s  = DATA;
          remain_s = remain_r - 8'd1;
        end
      end
      SKP_COM: begin
        state_s   = SKP_SET;
        set_cnt_s = 2'd0;
      end
      SKP_SET: begin
        if (set_cnt_r == (SKP_SET_LEN - 2'd1)) begin
          state_s = IDLE;
        end else begin
          set_cnt_s = set_cnt_r + 2'd1;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    // An aborted packet terminates with EDB in place of END.
    if (edb_s) begin
      ctrl_s = MUX_EDB;
    end else begin
      ctrl_s = state_ctrl(state_s);
    end
  end

  // Clear the SKP request on the edge that enters SKP_COM.
  always_comb begin
    skp_clr_s = (state_s == SKP_COM);
  end

  // State, counters and registered outputs.
  always_ff @(posedge ctrlCLK) begin
    if (ctrlRST) begin
      state_r   <= IDLE;
      remain_r  <= 8'd0;
      set_cnt_r <= 2'd0;
      ctrl_r    <= MUX_IDL;
      ack_r     <= 1'b0;
      rd_r      <= 1'b0;
      enb_r     <= 1'b0;
    end else begin
      state_r   <= state_s;
      remain_r  <= remain_s;
      set_cnt_r <= set_cnt_s;
      ctrl_r    <= ctrl_s;
      ack_r     <= (state_s == START);
      rd_r      <= (state_s == DATA) && !edb_s;
      enb_r     <= 1'b1;
    end
  end

  assign bus.muxCTRL = ctrl_r;
  assign bus.muxENB  = enb_r;
  assign bus.tlpACK  = ack_r;
  assign bus.tlpRD   = rd_r;
  assign bus.skpPEND = skp_pend_s;

endmodule

// File: tb/tb_framing_controller.sv
// Self-checking bench for framing_controller.
// dut_a (SKP_INTERVAL = 1180) runs a cycle-by-cycle vector table: reset,
// idle, single packet, back-to-back packets, abort and mid-packet reset.
// dut_b (SKP_INTERVAL = 8) runs a hand-written SKP insertion sequence.
module tb_framing_controller;

  typedef struct {
    logic       rst;
    logic       req;
    logic [7:0] len;
    logic       abort;
    logic [3:0] ctrl;
    logic       ack;
    logic       rd;
    logic       enb;
  } vec_t;

  logic clk;
  logic rst_a;
  logic rst_b;
  int   errors;
  int   checks;
  vec_t vecs[$];
  int   abort_lo;
  int   abort_hi;
  int   rd_total;

  framing_controller_if if_a ();
  framing_controller_if if_b ();

  framing_controller #(.SKP_INTERVAL(1180)) dut_a (
    .ctrlCLK (clk),
    .ctrlRST (rst_a),
    .bus     (if_a)
  );

  framing_controller #(.SKP_INTERVAL(8)) dut_b (
    .ctrlCLK (clk),
    .ctrlRST (rst_b),
    .bus     (if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic req, input logic [7:0] len,
                     input logic abort, input logic [3:0] ctrl, input logic ack,
                     input logic rd, input logic enb);
    vec_t v;
    v.rst = rst; v.req = req; v.len = len; v.abort = abort;
    v.ctrl = ctrl; v.ack = ack; v.rd = rd; v.enb = enb;
    vecs.push_back(v);
  endtask

  // Expected dut_b select k cycles after reset release with a 20-byte packet.
  function automatic logic [3:0] exp_b(input int k);
    if (k == 1) return 4'd4;
    else if (k <= 21) return 4'd0;
    else if (k == 22) return 4'd6;
    else if (k == 23) return 4'd1;
    else if (k <= 26) return 4'd3;
    else if (k == 27) return 4'd9;
    else return 4'd1;
  endfunction

  initial begin
    errors = 0;
    checks = 0;
    rd_total = 0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    if_a.tlpREQ = 1'b0; if_a.tlpLEN = 8'd0; if_a.tlpABORT = 1'b0;
    if_b.tlpREQ = 1'b0; if_b.tlpLEN = 8'd0; if_b.tlpABORT = 1'b0;

    // Reset, then 20 idle cycles (abort outside DATA is ignored).
    add(1'b1, 1'b0, 8'd0, 1'b0, 4'd9, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 8'd0, 1'b0, 4'd9, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++)
      add(1'b0, 1'b0, 8'd0, (i == 5), 4'd9, 1'b0, 1'b0, 1'b1);

    // Single packet, length 3: 4,0,0,0,6,9.
    add(1'b0, 1'b1, 8'd3, 1'b0, 4'd4, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++)
      add(1'b0, 1'b0, 8'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
    add(1'b0, 1'b0, 8'd0, 1'b0, 4'd6, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 8'd0, 1'b0, 4'd9, 1'b0, 1'b0, 1'b1);

    // Back-to-back packets, lengths 2 and 0: 4,0,0,6,4,6,9.
    add(1'b0, 1'b1, 8'd2, 1'b0, 4'd4, 1'b1, 1'b0, 1'b1);
    add(1'b0, 1'b0, 8'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
    add(1'b0, 1'b0, 8'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
    add(1'b0, 1'b1, 8'd0, 1'b0, 4'd6, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 8'd0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b1);
    add(1'b0, 1'b0, 8'd0, 1'b0, 4'd6, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 8'd0, 1'b0, 4'd9, 1'b0, 1'b0, 1'b1);

    // Length 10, abort sampled during the 4th TLP cycle.
    abort_lo = vecs.size();
    add(1'b0, 1'b1, 8'd10, 1'b0, 4'd4, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++)
      add(1'b0, 1'b0, 8'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
`ifdef FRAMING_ABORT_EN
    add(1'b0, 1'b0, 8'd0, 1'b1, 4'd7, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 8'd0, 1'b0, 4'd9, 1'b0, 1'b0, 1'b1);
`else
    add(1'b0, 1'b0, 8'd0, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++)
      add(1'b0, 1'b0, 8'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
    add(1'b0, 1'b0, 8'd0, 1'b0, 4'd6, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 8'd0, 1'b0, 4'd9, 1'b0, 1'b0, 1'b1);
`endif
    abort_hi = vecs.size();

    // Reset during the 2nd TLP cycle, then a clean length-1 packet.
    add(1'b0, 1'b1, 8'd5, 1'b0, 4'd4, 1'b1, 1'b0, 1'b1);
    add(1'b0, 1'b0, 8'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
    add(1'b0, 1'b0, 8'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
    add(1'b1, 1'b0, 8'd0, 1'b0, 4'd9, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 8'd0, 1'b0, 4'd9, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 8'd1, 1'b0, 4'd4, 1'b1, 1'b0, 1'b1);
    add(1'b0, 1'b0, 8'd0, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1);
    add(1'b0, 1'b0, 8'd0, 1'b0, 4'd6, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 8'd0, 1'b0, 4'd9, 1'b0, 1'b0, 1'b1);

    // Apply the table to dut_a.
    for (int i = 0; i < vecs.size(); i++) begin
      rst_a         = vecs[i].rst;
      if_a.tlpREQ   = vecs[i].req;
      if_a.tlpLEN   = vecs[i].len;
      if_a.tlpABORT = vecs[i].abort;
      tick();
      chk($sformatf("v%0d muxCTRL", i), 32'(if_a.muxCTRL), 32'(vecs[i].ctrl));
      chk($sformatf("v%0d tlpACK", i),  32'(if_a.tlpACK),  32'(vecs[i].ack));
      chk($sformatf("v%0d tlpRD", i),   32'(if_a.tlpRD),   32'(vecs[i].rd));
      chk($sformatf("v%0d muxENB", i),  32'(if_a.muxENB),  32'(vecs[i].enb));
      if (i >= abort_lo && i < abort_hi && if_a.tlpRD === 1'b1) rd_total++;
    end
`ifdef FRAMING_ABORT_EN
    chk("abort tlpRD total", 32'(rd_total), 32'd4);
`else
    chk("abort tlpRD total", 32'(rd_total), 32'd10);
`endif

    // SKP insertion on dut_b: 20-byte packet in flight across the wrap.
    tick();
    chk("b reset skpPEND", 32'(if_b.skpPEND), 32'd0);
    chk("b reset muxCTRL", 32'(if_b.muxCTRL), 32'd9);
    rst_b       = 1'b0;
    if_b.tlpREQ = 1'b1;
    if_b.tlpLEN = 8'd20;
    rd_total    = 0;
    for (int k = 1; k <= 28; k++) begin
      tick();
      if_b.tlpREQ = 1'b0;
      chk($sformatf("b%0d muxCTRL", k), 32'(if_b.muxCTRL), 32'(exp_b(k)));
      chk($sformatf("b%0d tlpACK", k), 32'(if_b.tlpACK), (k == 1) ? 32'd1 : 32'd0);
      if (if_b.tlpRD === 1'b1) rd_total++;
      if (k == 7 || k == 23)
        chk($sformatf("b%0d skpPEND", k), 32'(if_b.skpPEND), 32'd0);
      else if (k == 8 || k == 22 || k == 24)
        chk($sformatf("b%0d skpPEND", k), 32'(if_b.skpPEND), 32'd1);
    end
    chk("b tlpRD total", 32'(rd_total), 32'd20);
    chk("b muxENB", 32'(if_b.muxENB), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/framing_controller.md
# framing_controller

Sequencer that drives the 4-bit select and enable of the symbol multiplexer to frame outgoing packets. Each packet is sent as STP, N TLP bytes, then END. SKP ordered sets (COM followed by three SKP) are inserted periodically, and IDL is sent when there is nothing else to send. It sits between the transaction-layer byte source and the multiplexer, pacing the source through a pop strobe.

## Interface
- SKP_INTERVAL, 1180, cycles between SKP ordered-set requests (legal range 8..4095)
- ctrlCLK  input  1  clock, same clock as muxCLK
- ctrlRST  input  1  synchronous, active-high reset
- tlpREQ  input  1  packet ready at the byte source; level, held until tlpACK
- tlpLEN  input  8  data byte count of the requested packet, sampled with tlpACK; 0 means no data bytes
- tlpABORT  input  1  nullify the current packet; port always present, functional only under FRAMING_ABORT_EN
- tlpACK  output  1  one-cycle pulse: packet accepted, tlpLEN latched
- tlpRD  output  1  pop strobe to the byte source; high exactly on cycles where muxCTRL = TLP
- muxCTRL  output  4  select to the multiplexer: TLP 0, COM 1, PAD 2, SKP 3, STP 4, SDP 5, END 6, EDB 7, FTS 8, IDL 9
- muxENB  output  1  enable to the multiplexer
- skpPEND  output  1  SKP ordered set requested and not yet started

## Operation
- All outputs are registered.
- Reset values: muxCTRL = 9 (IDL), muxENB = 0, tlpACK = 0, tlpRD = 0, skpPEND = 0. The state machine returns to IDLE and the interval counter to 0.
- muxENB rises on the first cycle after reset is released and stays high.
- State machine:
  - IDLE → SKP_COM if skpPEND is set.
  - IDLE → START if tlpREQ is high (skpPEND has priority).
  - IDLE otherwise (output IDL).
  - START (output STP, tlpACK pulse, latch tlpLEN) → DATA if the length is nonzero, else → END.
  - DATA (output TLP, tlpRD = 1) for exactly the latched length in cycles → END.
  - END (output END) → same decision as IDLE, so back-to-back packets and SKP insertion need no idle gap.
  - SKP_COM (output COM) → SKP_SET, which outputs SKP for exactly 3 cycles → IDLE.
- SKP insertion happens only at a packet boundary (IDLE or END decision), never inside STP..END.
- Interval counter:
  - Free-runs 0..SKP_INTERVAL-1 and wraps to 0.
  - The wrap cycle sets skpPEND.
  - Entering SKP_COM clears skpPEND.
  - A wrap while skpPEND is already set is absorbed; at most one request is outstanding.
  - If a wrap and entry into SKP_COM fall in the same cycle, set wins and skpPEND stays 1.
- tlpREQ dropping before tlpACK withdraws the request; the controller keeps sending IDL.
- Reset asserted mid-packet or mid-ordered-set: the next cycle shows reset values. No END or EDB is emitted for the truncated frame.

## Timing
- Latency from tlpREQ sampled high in IDLE (no SKP pending) to muxCTRL = STP: 1 cycle.
- The multiplexer adds one more register stage, so muxOUT trails muxCTRL by 1 cycle. The byte source must present the byte on the cycle after tlpRD.
- Packet of length N occupies N + 2 cycles on muxCTRL. A SKP ordered set occupies 4 cycles.
- Worst-case SKP service delay: 257 cycles (maximum packet in flight) plus 1.

## Configuration
- FRAMING_ABORT_EN defined:
  - tlpABORT sampled high in DATA makes the next muxCTRL = EDB (7) instead of the remaining TLP bytes and END.
  - tlpRD drops in that same EDB cycle.
  - The next state then follows the END decision.
  - tlpABORT is ignored outside DATA.
- FRAMING_ABORT_EN undefined: tlpABORT is ignored and EDB is never produced.

## Structure
- Shared package framing_pkg: the ten 4-bit select encodings as named constants, the state enum (IDLE, START, DATA, END, SKP_COM, SKP_SET), and the SKP set length constant 3.
- One sub-module, skp_scheduler: the interval counter plus the skpPEND set/clear logic, with clear input "entering SKP_COM".
- The framing state machine and byte counter live in framing_controller.

## Test plan
- Reset then idle, tlpREQ = 0 for 20 cycles (SKP_INTERVAL = 1180) → muxCTRL = 9 every cycle, muxENB = 1 from cycle 1, tlpACK = 0.
- tlpREQ = 1 with tlpLEN = 3 → muxCTRL 4, 0, 0, 0, 6, 9. tlpACK is high only in the STP cycle and tlpRD is high for exactly 3 cycles.
- Two back-to-back requests (tlpLEN = 2, then tlpLEN = 0) → 4, 0, 0, 6, 4, 6 with no IDL between the packets.
- SKP_INTERVAL = 8 with tlpLEN = 20 in flight when the counter wraps → skpPEND = 1, the packet completes untouched, then 1, 3, 3, 3 immediately after END, and skpPEND = 0.
- With FRAMING_ABORT_EN, tlpLEN = 10 and tlpABORT pulsed during the 4th TLP cycle → exactly 4 TLP cycles, then 7, then 9; tlpRD total = 4.
- ctrlRST asserted during the 2nd TLP cycle → next cycle muxCTRL = 9, muxENB = 0, tlpRD = 0. After release the first new packet starts cleanly with STP.
